mtc_link_scheduler: RTL and testbench

Round-robin scheduler that shares one MTC-to-Sector-Logic output link between `c_MAX_NUM_SL` MTC candidate sources (primary plus neighbouring sectors). Each source has a small FIFO, so several candidates arriving in the same cycle are serialised onto the link rather than flagged as a mapping error. The block sits between the per-sector MTC builders and the SL link serializer. It also enforces a programmable link slot period and counts words dropped on FIFO overflow.

---
 rtl/mtc_link_scheduler.sv | 89 ++++++++
 tb/tb_mtc_link_scheduler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mtc_link_scheduler.sv
// mtc_link_scheduler: round-robin arbiter serialising per-source MTC FIFOs onto one SL link
module mtc_link_scheduler #(
  parameter int c_MAX_NUM_SL = 3,
  parameter int c_FIFO_DEPTH = 4,
  parameter int c_SLOT_CYCLES = 1,
  parameter int MTC2SL_LEN = 32,
  localparam int SW = c_MAX_NUM_SL > 1 ? $clog2(c_MAX_NUM_SL) : 1
) (
  input  logic                                     clock,
  input  logic                                     rst,
  input  logic [c_MAX_NUM_SL-1:0][MTC2SL_LEN-1:0]  mtc_in,
  input  logic                                     enable,
  input  logic                                     flush,
  output logic [MTC2SL_LEN-1:0]                    mtc2sl,
  output logic [SW-1:0]                            mtc2sl_src,
  output logic [c_MAX_NUM_SL-1:0]                  fifo_full,
  output logic [15:0]                              drop_count
);
  localparam int PW = $clog2(c_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = c_SLOT_CYCLES > 1 ? $clog2(c_SLOT_CYCLES) : 1;
  logic [MTC2SL_LEN-1:0] mem [c_MAX_NUM_SL][c_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [c_MAX_NUM_SL];
  logic [PW-1:0] rd_ptr [c_MAX_NUM_SL];
  logic [CW-1:0] cnt [c_MAX_NUM_SL];
  logic [SW-1:0] last_grant, sel, idx;
  logic [TW-1:0] slot;
  logic grant;
  logic [c_MAX_NUM_SL-1:0] push, pop, accept, drop;
  logic [16:0] drop_sum;
  always_comb begin
    sel = '0;
    idx = '0;
    grant = 1'b0;
    // walking from the farthest candidate down leaves the nearest non-empty source in sel
    for (int k = c_MAX_NUM_SL; k >= 1; k--) begin
      idx = SW'((int'(last_grant) + k) % c_MAX_NUM_SL);
      if (cnt[idx] != '0) begin
        sel = idx;
        grant = 1'b1;
      end
    end
    grant = grant && enable && slot == '0 && !flush;
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < c_MAX_NUM_SL; i++) begin
      pop[i] = grant && sel == SW'(i);
      push[i] = mtc_in[i][MTC2SL_LEN-1] && !flush;
      accept[i] = push[i] && (cnt[i] != CW'(c_FIFO_DEPTH) || pop[i]);
      drop[i] = push[i] && !accept[i];
      fifo_full[i] = cnt[i] == CW'(c_FIFO_DEPTH);
      drop_sum = drop_sum + 17'(drop[i]);
    end
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < c_MAX_NUM_SL; i++)
      if (accept[i]) mem[i][wr_ptr[i]] <= mtc_in[i];
  end
  always_ff @(posedge clock) begin
    if (!rst) begin
      slot <= '0;
      last_grant <= SW'(c_MAX_NUM_SL - 1);
      mtc2sl <= '0;
      mtc2sl_src <= '0;
      drop_count <= '0;
      for (int i = 0; i < c_MAX_NUM_SL; i++) begin
        cnt[i] <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      slot <= (!enable || slot == TW'(c_SLOT_CYCLES - 1)) ? '0 : slot + TW'(1);
      if (grant) last_grant <= sel;
      mtc2sl <= grant ? mem[sel][rd_ptr[sel]] : '0;
      mtc2sl_src <= grant ? sel : '0;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int i = 0; i < c_MAX_NUM_SL; i++) begin
        if (flush) begin
          cnt[i] <= '0;
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(accept[i]) - CW'(pop[i]);
          if (accept[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
          if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mtc_link_scheduler.sv
// tb_mtc_link_scheduler: two DUTs (slot period 1 and 3) checked against a queue-based model via scoreboard
module tb_mtc_link_scheduler;
  localparam int L = 32;
  localparam int N = 3;
  localparam int D = 4;
  typedef struct {
    logic [L-1:0] w;
    int src;
    int cyc;
  } exp_t;
  logic clock = 1'b0;
  logic rst, enable, flush;
  logic [N-1:0][L-1:0] mtc_in;
  logic [L-1:0] out_w [2];
  logic [1:0] out_src [2];
  logic [N-1:0] full [2];
  logic [15:0] dcnt [2];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [L-1:0] mq [2][N][$];
  exp_t sbq [2][$];
  int slot [2];
  int lg [2];
  int mdrop [2];
  int g;
  exp_t me, ce;
  logic [N-1:0] exp_full [2];
  int exp_drop [2];

  always #5 clock = ~clock;

  mtc_link_scheduler #(.c_MAX_NUM_SL(N), .c_FIFO_DEPTH(D), .c_SLOT_CYCLES(1), .MTC2SL_LEN(L)) dut0 (
    .clock(clock), .rst(rst), .mtc_in(mtc_in), .enable(enable), .flush(flush),
    .mtc2sl(out_w[0]), .mtc2sl_src(out_src[0]), .fifo_full(full[0]), .drop_count(dcnt[0]));
  mtc_link_scheduler #(.c_MAX_NUM_SL(N), .c_FIFO_DEPTH(D), .c_SLOT_CYCLES(3), .MTC2SL_LEN(L)) dut1 (
    .clock(clock), .rst(rst), .mtc_in(mtc_in), .enable(enable), .flush(flush),
    .mtc2sl(out_w[1]), .mtc2sl_src(out_src[1]), .fifo_full(full[1]), .drop_count(dcnt[1]));

  task automatic check(input bit ok, input string nm, input string act, input string exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %s, expected %s", nm, act, exp);
    end
  endtask

  // reference model: per-source queues, round-robin pick, drops when a queue is still full after the pop
  always @(posedge clock) begin
    cyc++;
    for (int s = 0; s < 2; s++) begin
      if (!rst) begin
        for (int i = 0; i < N; i++) mq[s][i].delete();
        slot[s] = 0;
        lg[s] = N - 1;
        mdrop[s] = 0;
      end else begin
        g = -1;
        if (enable && slot[s] == 0 && !flush)
          for (int j = 1; j <= N && g < 0; j++)
            if (mq[s][(lg[s] + j) % N].size() > 0) g = (lg[s] + j) % N;
        if (g >= 0) begin
          me.w = mq[s][g].pop_front();
          me.src = g;
          me.cyc = cyc;
          sbq[s].push_back(me);
          lg[s] = g;
        end
        if (flush) begin
          for (int i = 0; i < N; i++) mq[s][i].delete();
        end else begin
          for (int i = 0; i < N; i++)
            if (mtc_in[i][L-1]) begin
              if (mq[s][i].size() < D) mq[s][i].push_back(mtc_in[i]);
              else if (mdrop[s] < 65535) mdrop[s]++;
            end
        end
        slot[s] = enable ? (slot[s] + 1) % (s == 0 ? 1 : 3) : 0;
      end
      for (int i = 0; i < N; i++) exp_full[s][i] = mq[s][i].size() == D;
      exp_drop[s] = mdrop[s];
    end
  end

  always @(negedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (out_w[s][L-1]) begin
        if (sbq[s].size() == 0) begin
          check(1'b0, $sformatf("unexpected_out%0d", s), $sformatf("%h src %0d", out_w[s], out_src[s]), "no word");
        end else begin
          ce = sbq[s].pop_front();
          check(out_w[s] == ce.w && int'(out_src[s]) == ce.src && cyc == ce.cyc, $sformatf("out%0d", s),
                $sformatf("%h src %0d cyc %0d", out_w[s], out_src[s], cyc),
                $sformatf("%h src %0d cyc %0d", ce.w, ce.src, ce.cyc));
        end
      end else begin
        check(out_w[s] == '0 && out_src[s] == '0, $sformatf("idle%0d", s),
              $sformatf("%h src %0d", out_w[s], out_src[s]), "0 src 0");
        if (sbq[s].size() != 0 && sbq[s][0].cyc <= cyc) begin
          ce = sbq[s].pop_front();
          check(1'b0, $sformatf("missing_out%0d", s), "no word", $sformatf("%h src %0d cyc %0d", ce.w, ce.src, ce.cyc));
        end
      end
      check(dcnt[s] == 16'(exp_drop[s]), $sformatf("drop_count%0d", s), $sformatf("%0d", dcnt[s]), $sformatf("%0d", exp_drop[s]));
      check(full[s] == exp_full[s], $sformatf("fifo_full%0d", s), $sformatf("%b", full[s]), $sformatf("%b", exp_full[s]));
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic en, input logic fl, input logic rn);
    for (int i = 0; i < N; i++) mtc_in[i] = {v[i], 31'($urandom)};
    enable = en;
    flush = fl;
    rst = rn;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(3'b000, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    mtc_in = '0;
    enable = 1'b1;
    flush = 1'b0;
    rst = 1'b0;
    repeat (4) drive(3'b000, 1'b1, 1'b0, 1'b0);
    idle(1);
    drive(3'b010, 1'b1, 1'b0, 1'b1);
    idle(8);
    drive(3'b111, 1'b1, 1'b0, 1'b1);
    idle(12);
    repeat (6) drive(3'b001, 1'b0, 1'b0, 1'b1);
    check(full[0][0] == 1'b1, "overflow_full", $sformatf("%b", full[0][0]), "1");
    check(dcnt[0] == 16'd2, "overflow_drop0", $sformatf("%0d", dcnt[0]), "2");
    check(dcnt[1] == 16'd2, "overflow_drop1", $sformatf("%0d", dcnt[1]), "2");
    idle(15);
    repeat (6) drive(3'b100, 1'b1, 1'b0, 1'b1);
    idle(20);
    repeat (3) drive(3'b001, 1'b0, 1'b0, 1'b1);
    drive(3'b111, 1'b1, 1'b1, 1'b1);
    idle(8);
    repeat (3) drive(3'b001, 1'b0, 1'b0, 1'b1);
    drive(3'b111, 1'b1, 1'b0, 1'b0);
    idle(8);
    repeat (12) drive(3'b101, 1'b1, 1'b0, 1'b1);
    idle(20);
    repeat (400)
      drive(N'($urandom), $urandom_range(3) != 0, $urandom_range(31) == 0, $urandom_range(63) != 0);
    idle(40);
    for (int s = 0; s < 2; s++)
      check(sbq[s].size() == 0, $sformatf("drained%0d", s), $sformatf("%0d pending", sbq[s].size()), "0 pending");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
